// File: rtl/rf_wb_arbiter.sv
// Register-file writeback arbiter: round-robin ALU/LSU selection, one registered
// write per cycle, and a per-register pending-write scoreboard.
module rf_wb_arbiter #(
  parameter int AWIDTH = 5,
  parameter int DWIDTH = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   alu_valid_i,
  input  logic [AWIDTH-1:0]      alu_waddr_i,
  input  logic [DWIDTH-1:0]      alu_wdata_i,
  output logic                   alu_ready_o,
  input  logic                   lsu_valid_i,
  input  logic [AWIDTH-1:0]      lsu_waddr_i,
  input  logic [DWIDTH-1:0]      lsu_wdata_i,
  output logic                   lsu_ready_o,
  input  logic                   alloc_en_i,
  input  logic [AWIDTH-1:0]      alloc_addr_i,
  output logic [(1<<AWIDTH)-1:0] busy_o,
  output logic                   rf_wen_o,
  output logic [AWIDTH-1:0]      rf_waddr_o,
  output logic [DWIDTH-1:0]      rf_wdata_o
);

  localparam int NREG = 1 << AWIDTH;

  logic              last_grant_lsu;
  logic              gnt_alu, gnt_lsu, accept;
  logic [AWIDTH-1:0] waddr_p0;
  logic [DWIDTH-1:0] wdata_p0;
  logic              vld_p0;
  logic              vld_p1;
  logic [AWIDTH-1:0] waddr_p1;
  logic [DWIDTH-1:0] wdata_p1;
  logic [NREG-1:0]   busy_q, busy_nxt;

  // Stage 0: grant selection and request mux (combinational)
  always_comb begin
    gnt_alu = 1'b0;
    gnt_lsu = 1'b0;
    if (!rst_i) begin
      if (alu_valid_i && lsu_valid_i) begin
        gnt_alu = last_grant_lsu;
        gnt_lsu = !last_grant_lsu;
      end else begin
        gnt_alu = alu_valid_i;
        gnt_lsu = lsu_valid_i;
      end
    end
    accept   = gnt_alu || gnt_lsu;
    waddr_p0 = gnt_lsu ? lsu_waddr_i : alu_waddr_i;
    wdata_p0 = gnt_lsu ? lsu_wdata_i : alu_wdata_i;
    // x0 writes are consumed but never reach the register file
    vld_p0   = accept && (waddr_p0 != '0);
  end

  assign alu_ready_o = gnt_alu;
  assign lsu_ready_o = gnt_lsu;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_grant_lsu <= 1'b1;
    end else if (gnt_alu) begin
      last_grant_lsu <= 1'b0;
    end else if (gnt_lsu) begin
      last_grant_lsu <= 1'b1;
    end
  end

  // Stage 1: registered write port toward the register file
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_p1   <= 1'b0;
      waddr_p1 <= '0;
      wdata_p1 <= '0;
    end else begin
      vld_p1 <= vld_p0;
      if (accept) begin
        waddr_p1 <= waddr_p0;
        wdata_p1 <= wdata_p0;
      end
    end
  end

  assign rf_wen_o   = vld_p1;
  assign rf_waddr_o = waddr_p1;
  assign rf_wdata_o = wdata_p1;

  // Scoreboard: clear on commit, then set so a new allocation overrides the clear
  always_comb begin
    busy_nxt = busy_q;
    if (vld_p1) begin
      busy_nxt[waddr_p1] = 1'b0;
    end
    if (alloc_en_i) begin
      busy_nxt[alloc_addr_i] = 1'b1;
    end
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_nxt;
    end
  end

  assign busy_o = busy_q;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Bench for rf_wb_arbiter: directed vector table, multi-cycle corner sequences,
// and randomized traffic scored against a rule-level reference model.
module tb_rf_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid, lsu_valid, alloc_en;
  logic [4:0]  alu_waddr, lsu_waddr, alloc_addr;
  logic [31:0] alu_wdata, lsu_wdata;
  logic        alu_ready, lsu_ready, rf_wen;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [31:0] busy;

  int checks = 0;
  int passed = 0;

  rf_wb_arbiter #(.AWIDTH(5), .DWIDTH(32)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .alu_valid_i (alu_valid),
    .alu_waddr_i (alu_waddr),
    .alu_wdata_i (alu_wdata),
    .alu_ready_o (alu_ready),
    .lsu_valid_i (lsu_valid),
    .lsu_waddr_i (lsu_waddr),
    .lsu_wdata_i (lsu_wdata),
    .lsu_ready_o (lsu_ready),
    .alloc_en_i  (alloc_en),
    .alloc_addr_i(alloc_addr),
    .busy_o      (busy),
    .rf_wen_o    (rf_wen),
    .rf_waddr_o  (rf_waddr),
    .rf_wdata_o  (rf_wdata)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks so far", passed, checks);
    $fatal(1);
  end

  typedef struct {
    logic        rst;
    logic        av;
    logic [4:0]  aa;
    logic [31:0] ad;
    logic        lv;
    logic [4:0]  la;
    logic [31:0] ld;
    logic        ae;
    logic [4:0]  al;
    logic        ar;
    logic        lr;
    logic        wen;
    logic [4:0]  wa;
    logic [31:0] wd;
  } vec_t;

  vec_t tv[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic drive(input logic r, input logic av, input logic [4:0] aa, input logic [31:0] ad,
                       input logic lv, input logic [4:0] la, input logic [31:0] ld,
                       input logic ae, input logic [4:0] al);
    rst = r; alu_valid = av; alu_waddr = aa; alu_wdata = ad;
    lsu_valid = lv; lsu_waddr = la; lsu_wdata = ld; alloc_en = ae; alloc_addr = al;
  endtask

  task automatic idle(input logic r);
    drive(r, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic row(input logic r, input logic av, input logic [4:0] aa, input logic [31:0] ad,
                     input logic lv, input logic [4:0] la, input logic [31:0] ld,
                     input logic ae, input logic [4:0] al,
                     input logic ar, input logic lr, input logic wen,
                     input logic [4:0] wa, input logic [31:0] wd);
    vec_t v;
    v.rst = r; v.av = av; v.aa = aa; v.ad = ad; v.lv = lv; v.la = la; v.ld = ld;
    v.ae = ae; v.al = al; v.ar = ar; v.lr = lr; v.wen = wen; v.wa = wa; v.wd = wd;
    tv.push_back(v);
  endtask

  // reference model state
  logic [31:0] m_busy;
  logic        m_last_lsu;
  logic        m_pv;
  logic [4:0]  m_pa;
  logic [31:0] m_pd;

  initial begin
    idle(1'b1);
    tick;
    tick;

    //  rst   av    aa     ad            lv    la     ld        ae    al     ar    lr    wen   wa     wd
    row(1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 1'b1, 5'd6, 32'h66,   1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
    row(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
    row(1'b0, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd5, 32'hDEADBEEF);
    row(1'b1, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
    row(1'b0, 1'b1, 5'd1, 32'h11,       1'b1, 5'd2, 32'h22,   1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
    row(1'b0, 1'b1, 5'd1, 32'h11,       1'b1, 5'd2, 32'h22,   1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 5'd1, 32'h11);
    row(1'b0, 1'b1, 5'd1, 32'h11,       1'b1, 5'd2, 32'h22,   1'b0, 5'd0, 1'b1, 1'b0, 1'b1, 5'd2, 32'h22);
    row(1'b0, 1'b1, 5'd1, 32'h11,       1'b1, 5'd2, 32'h22,   1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 5'd1, 32'h11);
    row(1'b0, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd2, 32'h22);
    row(1'b0, 1'b1, 5'd0, 32'h55,       1'b0, 5'd0, 32'h0,    1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
    row(1'b0, 1'b0, 5'd0, 32'h0,        1'b1, 5'd3, 32'h33,   1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 5'd0, 32'd0);
    row(1'b0, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd3, 32'h33);

    foreach (tv[i]) begin
      drive(tv[i].rst, tv[i].av, tv[i].aa, tv[i].ad, tv[i].lv, tv[i].la, tv[i].ld, tv[i].ae, tv[i].al);
      #3;
      chk($sformatf("vec%0d_alu_ready", i), 32'(alu_ready), 32'(tv[i].ar));
      chk($sformatf("vec%0d_lsu_ready", i), 32'(lsu_ready), 32'(tv[i].lr));
      chk($sformatf("vec%0d_rf_wen", i), 32'(rf_wen), 32'(tv[i].wen));
      if (tv[i].wen) begin
        chk($sformatf("vec%0d_rf_waddr", i), 32'(rf_waddr), 32'(tv[i].wa));
        chk($sformatf("vec%0d_rf_wdata", i), rf_wdata, tv[i].wd);
      end
      chk($sformatf("vec%0d_busy", i), busy, 32'd0);
      tick;
    end

    // scoreboard set, then cleared by the committing edge
    drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7);
    tick;
    drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h77, 1'b0, 5'd0);
    #3;
    chk("sb7_set", 32'(busy[7]), 32'd1);
    chk("sb7_lsu_ready", 32'(lsu_ready), 32'd1);
    tick;
    idle(1'b0);
    #3;
    chk("sb7_held", 32'(busy[7]), 32'd1);
    chk("sb7_wen", 32'(rf_wen), 32'd1);
    chk("sb7_waddr", 32'(rf_waddr), 32'd7);
    chk("sb7_wdata", rf_wdata, 32'h77);
    tick;
    #3;
    chk("sb7_cleared", 32'(busy[7]), 32'd0);

    // set wins over a same-edge clear
    drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9);
    tick;
    drive(1'b0, 1'b1, 5'd9, 32'h99, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    #3;
    chk("sw9_alu_ready", 32'(alu_ready), 32'd1);
    chk("sw9_busy_pre", 32'(busy[9]), 32'd1);
    tick;
    drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9);
    #3;
    chk("sw9_wen", 32'(rf_wen), 32'd1);
    chk("sw9_waddr", 32'(rf_waddr), 32'd9);
    tick;
    idle(1'b0);
    #3;
    chk("sw9_busy_post", 32'(busy[9]), 32'd1);
    chk("sw9_wen_off", 32'(rf_wen), 32'd0);
    tick;

    // reset mid-flight: ALU won last, reset must restore ALU priority
    drive(1'b0, 1'b1, 5'd4, 32'h44, 1'b0, 5'd0, 32'd0, 1'b1, 5'd6);
    #3;
    chk("rst_alu_ready", 32'(alu_ready), 32'd1);
    tick;
    idle(1'b1);
    #3;
    chk("rst_wen_before", 32'(rf_wen), 32'd1);
    chk("rst_ready_in_reset", 32'(alu_ready | lsu_ready), 32'd0);
    tick;
    drive(1'b0, 1'b1, 5'd1, 32'hA1, 1'b1, 5'd2, 32'hB2, 1'b0, 5'd0);
    #3;
    chk("rst_wen_after", 32'(rf_wen), 32'd0);
    chk("rst_waddr_after", 32'(rf_waddr), 32'd0);
    chk("rst_wdata_after", rf_wdata, 32'd0);
    chk("rst_busy_after", busy, 32'd0);
    chk("rst_tie_alu", 32'(alu_ready), 32'd1);
    chk("rst_tie_lsu", 32'(lsu_ready), 32'd0);
    tick;
    idle(1'b0);
    #3;
    chk("rst_tie_write", 32'(rf_waddr), 32'd1);
    tick;

    // randomized traffic against the reference model
    begin
      logic r, av, lv, ae, e_ar, e_lr;
      logic [4:0] aa, la, al;
      logic [31:0] ad, ld;
      av = 1'b0; lv = 1'b0; aa = 5'd0; la = 5'd0; ad = 32'd0; ld = 32'd0;
      m_busy = 32'd0; m_last_lsu = 1'b1; m_pv = 1'b0; m_pa = 5'd0; m_pd = 32'd0;
      for (int n = 0; n < 400; n++) begin
        r = (n == 0) || ($urandom_range(0, 39) == 0);
        if (!av) begin
          av = ($urandom_range(0, 2) != 0);
          aa = 5'($urandom_range(0, 7));
          ad = $urandom;
        end
        if (!lv) begin
          lv = ($urandom_range(0, 2) != 0);
          la = 5'($urandom_range(0, 7));
          ld = $urandom;
        end
        ae = ($urandom_range(0, 1) == 1);
        al = 5'($urandom_range(0, 7));
        drive(r, av, aa, ad, lv, la, ld, ae, al);

        // winner: sole requester, or on a tie whoever did not win last
        e_ar = !r && av && (!lv || m_last_lsu);
        e_lr = !r && lv && (!av || !m_last_lsu);
        #3;
        if (n > 0) begin
          chk($sformatf("rnd%0d_alu_ready", n), 32'(alu_ready), 32'(e_ar));
          chk($sformatf("rnd%0d_lsu_ready", n), 32'(lsu_ready), 32'(e_lr));
          chk($sformatf("rnd%0d_rf_wen", n), 32'(rf_wen), 32'(m_pv));
          if (m_pv) begin
            chk($sformatf("rnd%0d_rf_waddr", n), 32'(rf_waddr), 32'(m_pa));
            chk($sformatf("rnd%0d_rf_wdata", n), rf_wdata, m_pd);
          end
          chk($sformatf("rnd%0d_busy", n), busy, m_busy);
        end

        if (r) begin
          m_busy = 32'd0; m_last_lsu = 1'b1; m_pv = 1'b0;
        end else begin
          if (m_pv) m_busy[m_pa] = 1'b0;
          if (ae && al != 5'd0) m_busy[al] = 1'b1;
          m_pv = 1'b0;
          if (e_ar) begin
            m_pv = (aa != 5'd0); m_pa = aa; m_pd = ad; m_last_lsu = 1'b0;
          end else if (e_lr) begin
            m_pv = (la != 5'd0); m_pa = la; m_pd = ld; m_last_lsu = 1'b1;
          end
        end
        if (e_ar) av = 1'b0;
        if (e_lr) lv = 1'b0;
        tick;
      end
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/rf_wb_arbiter.md
RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

Interface
REQ-001 Parameter AWIDTH, default 5: register address width; the register file has 2**AWIDTH entries.
REQ-002 Parameter DWIDTH, default 32: register data width.
REQ-003 The block SHALL use one clock and a synchronous, active-high reset.
REQ-004 clk_i  in  1  clock; all state updates on its rising edge.
REQ-005 rst_i  in  1  reset, synchronous, active-high.
REQ-006 alu_valid_i  in  1  ALU writeback request.
REQ-007 alu_waddr_i  in  AWIDTH  ALU destination register.
REQ-008 alu_wdata_i  in  DWIDTH  ALU result.
REQ-009 alu_ready_o  out  1  ALU request accepted this cycle.
REQ-010 lsu_valid_i  in  1  LSU (load) writeback request.
REQ-011 lsu_waddr_i  in  AWIDTH  LSU destination register.
REQ-012 lsu_wdata_i  in  DWIDTH  load data.
REQ-013 lsu_ready_o  out  1  LSU request accepted this cycle.
REQ-014 alloc_en_i  in  1  issue stage marks a destination register pending.
REQ-015 alloc_addr_i  in  AWIDTH  register being marked pending.
REQ-016 busy_o  out  2**AWIDTH  per-register pending-write bit vector.
REQ-017 rf_wen_o  out  1  register-file write enable.
REQ-018 rf_waddr_o  out  AWIDTH  register-file write address.
REQ-019 rf_wdata_o  out  DWIDTH  register-file write data.

Function
REQ-020 Handshake: a request is accepted in a cycle where valid_i=1 and ready_o=1; the requester SHALL hold valid, waddr and wdata stable until accepted.
REQ-021 ready_o is combinational and asserts only for the granted requester; it never asserts while that requester's valid_i=0.
REQ-022 At most one request is accepted per cycle.
REQ-023 Single valid requester: it is granted in the same cycle.
REQ-024 Both valid: round-robin; the requester not granted most recently wins; last_grant updates only on an accepted request.
REQ-025 last_grant resets to LSU, so the ALU wins the first tie after reset.
REQ-026 Output stage is registered: a request accepted at edge N drives rf_wen_o/rf_waddr_o/rf_wdata_o during cycle N+1 (latency 1); with no acceptance at edge N, rf_wen_o=0 in cycle N+1.
REQ-027 An accepted request with waddr=0 is consumed with rf_wen_o=0 for the following cycle (x0 writes dropped); rf_waddr_o/rf_wdata_o are don't-care.
REQ-028 busy_o[i] for i≠0 is set at the edge where alloc_en_i=1 and alloc_addr_i=i.
REQ-029 busy_o[i] for i≠0 is cleared at the edge where rf_wen_o=1 and rf_waddr_o=i, i.e. the edge that commits the write to the register file.
REQ-030 Simultaneous set and clear of the same register at one edge: set wins and busy stays 1 (new in-flight writer).
REQ-031 busy_o[0] is constantly 0; alloc to address 0 is ignored.
REQ-032 Writeback to a register with busy=0 is legal: the write is performed and busy stays 0.
REQ-033 No back-pressure from the register file: the output stage drains every cycle, so throughput is one accepted write per cycle.

Reset
REQ-034 While rst_i=1 at an edge: rf_wen_o←0, rf_waddr_o←0, rf_wdata_o←0, busy_o←all 0, last_grant←LSU.
REQ-035 While rst_i=1, alu_ready_o and lsu_ready_o SHALL be 0; a request presented during reset is not accepted and is not written.
REQ-036 Reset mid-operation discards any registered pending write (rf_wen_o=0 in the cycle after the reset edge) and all busy bits.

Verification
REQ-037 Reset, then ALU only: alu_valid=1, waddr=5, wdata=0xDEADBEEF -> alu_ready=1 same cycle; next cycle rf_wen=1, rf_waddr=5, rf_wdata=0xDEADBEEF.
REQ-038 Both valid for 4 cycles after reset (ALU waddr=1, LSU waddr=2) -> grants ALU, LSU, ALU, LSU; the loser's ready=0; rf_waddr sequence 1,2,1,2 delayed one cycle.
REQ-039 Scoreboard: alloc addr=7 -> busy_o[7]=1 next cycle; LSU writeback to 7 accepted at edge N -> busy_o[7] stays 1 through cycle N+1 and reads 0 after edge N+1.
REQ-040 Set-wins: alloc addr=9 in the same cycle rf_wen=1, rf_waddr=9 -> busy_o[9]=1 after the edge.
REQ-041 x0: ALU waddr=0 valid, plus alloc addr=0 -> alu_ready=1, next cycle rf_wen=0, and busy_o[0]=0 throughout.
REQ-042 Reset mid-flight: request accepted at edge N, rst_i=1 at edge N+1 -> rf_wen=0 after edge N+1, busy_o=0, and the next tie grants the ALU.
